// File: rtl/iob2axil.sv
// IOb subordinate to AXI-Lite manager bridge; one outstanding transaction at a time.
// Nonzero write strobe selects a write, otherwise the request is a read.
module iob2axil #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned AXIL_ADDR_W = ADDR_W,
  parameter int unsigned AXIL_DATA_W = DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cke_i,
  // IOb subordinate
  input  logic                     iob_valid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/8-1:0]      iob_wstrb_i,
  output logic                     iob_ready_o,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o,
  input  logic                     iob_rready_i,
  // AXI-Lite manager
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]               axil_awprot_o,
  output logic                     axil_awvalid_o,
  input  logic                     axil_awready_i,
  output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
  output logic                     axil_wvalid_o,
  input  logic                     axil_wready_i,
  input  logic [1:0]               axil_bresp_i,
  input  logic                     axil_bvalid_i,
  output logic                     axil_bready_o,
  output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]               axil_arprot_o,
  output logic                     axil_arvalid_o,
  input  logic                     axil_arready_i,
  input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]               axil_rresp_i,
  input  logic                     axil_rvalid_i,
  output logic                     axil_rready_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata,
    StRresp
  } state_e;

  state_e                   state_q, state_d;
  logic [AXIL_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W/8-1:0]      wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iob_valid_i) begin
          addr_d  = AXIL_ADDR_W'(iob_addr_i);
          wdata_d = iob_wdata_i;
          wstrb_d = iob_wstrb_i;
          if (|iob_wstrb_i) begin
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = StRaddr;
          end
        end
      end
      StWrite: begin
        // AW and W channels retire independently; leave once both are done.
        if (axil_awready_i) awvalid_d = 1'b0;
        if (axil_wready_i)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axil_awready_i) && (!wvalid_q || axil_wready_i)) begin
          state_d = StWresp;
        end
      end
      StWresp: begin
        if (axil_bvalid_i) begin
          state_d = StIdle;
          err_d   = |axil_bresp_i;
        end
      end
      StRaddr: begin
        if (axil_arready_i) state_d = StRdata;
      end
      StRdata: begin
        if (axil_rvalid_i) begin
          rdata_d = axil_rdata_i;
          err_d   = |axil_rresp_i;
          state_d = StRresp;
        end
      end
      StRresp: begin
        if (iob_rready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign iob_ready_o    = (state_q == StIdle);
  assign iob_rvalid_o   = (state_q == StRresp);
  assign iob_rdata_o    = rdata_q;

  assign axil_awaddr_o  = addr_q;
  assign axil_awprot_o  = 3'b000;
  assign axil_awvalid_o = awvalid_q;
  assign axil_wdata_o   = wdata_q;
  assign axil_wstrb_o   = wstrb_q;
  assign axil_wvalid_o  = wvalid_q;
  assign axil_bready_o  = (state_q == StWresp);
  assign axil_araddr_o  = addr_q;
  assign axil_arprot_o  = 3'b000;
  assign axil_arvalid_o = (state_q == StRaddr);
  assign axil_rready_o  = (state_q == StRdata);
  assign err_o          = err_q;

endmodule

// File: doc/iob2axil.md
IOB2AXIL -- requirements
Module: iob2axil

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, IOb address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, IOb data width in bits; a multiple of 8.
REQ-003 SHALL have parameter AXIL_ADDR_W, default ADDR_W, AXI-Lite address width; AXIL_ADDR_W >= ADDR_W.
REQ-004 SHALL have parameter AXIL_DATA_W, default DATA_W, AXI-Lite data width; AXIL_DATA_W == DATA_W.
REQ-005 SHALL have ports clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high; cke_i in 1 clock enable.
REQ-006 SHALL have IOb subordinate ports: iob_valid_i in 1; iob_addr_i in ADDR_W; iob_wdata_i in DATA_W; iob_wstrb_i in DATA_W/8; iob_ready_o out 1; iob_rvalid_o out 1; iob_rdata_o out DATA_W; iob_rready_i in 1.
REQ-007 SHALL have AXI-Lite manager ports: axil_awaddr_o out AXIL_ADDR_W; axil_awprot_o out 3; axil_awvalid_o out 1; axil_awready_i in 1; axil_wdata_o out DATA_W; axil_wstrb_o out DATA_W/8; axil_wvalid_o out 1; axil_wready_i in 1; axil_bresp_i in 2; axil_bvalid_i in 1; axil_bready_o out 1; axil_araddr_o out AXIL_ADDR_W; axil_arprot_o out 3; axil_arvalid_o out 1; axil_arready_i in 1; axil_rdata_i in DATA_W; axil_rresp_i in 2; axil_rvalid_i in 1; axil_rready_o out 1.
REQ-008 SHALL have err_o out 1, one-cycle pulse on nonzero AXI response.

Function
REQ-009 SHALL implement one FSM: IDLE, WRITE, WRESP, RADDR, RDATA, RRESP; one outstanding transaction.
REQ-010 SHALL drive iob_ready_o = 1 only in IDLE (combinational); request accepted when iob_valid_i & iob_ready_o.
REQ-011 SHALL, on accept, register address (zero-extended to AXIL_ADDR_W), wdata, wstrb; |wstrb -> WRITE, else -> RADDR.
REQ-012 SHALL, entering WRITE, set axil_awvalid_o and axil_wvalid_o both to 1 on the next cycle; each clears independently after its own handshake (valid & ready) and never drops before it.
REQ-013 SHALL go WRITE -> WRESP on the cycle the last of the AW/W handshakes completes (same-cycle completion of both allowed).
REQ-014 SHALL hold axil_bready_o = 1 in WRESP only; on axil_bvalid_i -> IDLE; pulse err_o if axil_bresp_i != 0.
REQ-015 SHALL assert axil_arvalid_o in RADDR; on axil_arready_i -> RDATA.
REQ-016 SHALL hold axil_rready_o = 1 in RDATA only; on axil_rvalid_i register axil_rdata_i into iob_rdata_o, -> RRESP; pulse err_o if axil_rresp_i != 0.
REQ-017 SHALL hold iob_rvalid_o = 1 and iob_rdata_o stable in RRESP; on iob_rready_i -> IDLE; iob_rdata_o retains value afterwards.
REQ-018 SHALL drive axil_awprot_o = axil_arprot_o = 3'b000; axil_awaddr_o/axil_araddr_o = registered address at all times.
REQ-019 SHALL give minimum latency accept->iob_rvalid_o of 3 cycles with zero-wait AXI peer; write accept->next iob_ready_o of 3 cycles.
REQ-020 SHALL freeze all state and registered outputs while cke_i = 0; combinational outputs follow frozen state.
REQ-021 SHALL ignore iob_valid_i outside IDLE; no buffering of rejected requests.

Reset
REQ-022 SHALL, on rising clk_i with rst_i = 1 (regardless of cke_i), enter IDLE and clear all registers to 0.
REQ-023 SHALL have reset values: all valid/ready outputs 0 except iob_ready_o = 1; addresses, data, strobes, iob_rdata_o, err_o = 0.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation; no AXI valid held afterwards.

Verification
REQ-025 Write, zero-wait: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> awaddr 0x10, wdata 0xDEADBEEF, wstrb 0xF, bready seen, iob_ready_o high 3 cycles after accept.
REQ-026 Write, skewed: wready 4 cycles after awready -> awvalid drops after AW handshake, wvalid held until its handshake, single B.
REQ-027 Read: addr 0x24, slave returns 0x12345678 after 2 cycles -> araddr 0x24, iob_rvalid_o with 0x12345678 held until iob_rready_i.
REQ-028 Error: bresp 2'b10, then rresp 2'b11 -> err_o one-cycle pulse each; FSM returns IDLE.
REQ-029 cke_i low 5 cycles in WRESP with bvalid high -> no state change; completes once cke_i = 1.
REQ-030 rst_i in RDATA -> next cycle IDLE, rready/arvalid 0, iob_ready_o 1; following read completes normally.
